irq_ctrl: RTL and testbench

- Small external interrupt controller. It sits directly upstream of the machine CSR block and drives that block's ext_int input.
- Captures rising edges on NUM_SOURCES interrupt lines, masks them with a software enable register, and serializes them into one level on ext_int.
- Software acknowledges each interrupt with a claim/complete register pair, using the same available/busy/fault handshake as the CSR block.

---
 rtl/irq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl : edge-capturing external interrupt controller, claim/complete
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_ctrl #(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   available,
    input  logic                   write,
    input  logic [1:0]             addr,
    input  logic [31:0]            write_value,
    output logic [31:0]            read_value,
    output logic                   busy,
    output logic                   fault,
    output logic                   ext_int
);

    localparam int         WD        = (NUM_SOURCES > 5) ? NUM_SOURCES : 5;
    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_ENABLE  = 2'd1;
    localparam logic [1:0] A_CLAIM   = 2'd2;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        IN_PROGRESS = 2'd1,
        DONE        = 2'd2
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [NUM_SOURCES-1:0] r_sync1, r_sync2, r_sync3;
    logic [NUM_SOURCES-1:0] r_pending, r_enable;
    logic [4:0]             r_in_service;
    logic                   r_op_write;
    logic [1:0]             r_op_addr;
    logic [WD-1:0]          r_op_wdata;

    logic [NUM_SOURCES-1:0] w_claimable, w_claim_mask, w_pending_clr, w_enable_nx;
    logic [4:0]             w_claim_id, w_in_service_nx;
    logic                   w_found, w_busy_nx, w_fault_nx;
    logic [31:0]            w_read_nx;
    logic                   w_unused_wdata;

    assign w_unused_wdata = ^write_value[31:WD];

    // Lowest-index enabled pending source; scanning downward lets the lowest win.
    always_comb begin
        w_claimable  = r_pending & r_enable;
        w_found      = 1'b0;
        w_claim_id   = 5'd0;
        w_claim_mask = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_claimable[i]) begin
                w_found         = 1'b1;
                w_claim_id      = 5'(i + 1);
                w_claim_mask    = '0;
                w_claim_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_busy_nx       = busy;
        w_fault_nx      = 1'b0;
        w_read_nx       = read_value;
        w_enable_nx     = r_enable;
        w_in_service_nx = r_in_service;
        w_pending_clr   = '0;
        case (r_state)
            IDLE: begin
                w_busy_nx = available;
                if (available) begin
                    w_state_nx = IN_PROGRESS;
                end
            end
            IN_PROGRESS: begin
                w_busy_nx  = 1'b0;
                w_state_nx = DONE;
                w_read_nx  = 32'd0;
                case (r_op_addr)
                    A_PENDING: begin
                        if (r_op_write) begin
                            w_fault_nx = 1'b1;
                        end else begin
                            w_read_nx = 32'(r_pending);
                        end
                    end
                    A_ENABLE: begin
                        w_read_nx = 32'(r_enable);
                        if (r_op_write) begin
                            w_enable_nx = r_op_wdata[NUM_SOURCES-1:0];
                        end
                    end
                    A_CLAIM: begin
                        if (r_op_write || (r_in_service != 5'd0)) begin
                            w_fault_nx = 1'b1;
                        end else if (w_found) begin
                            w_read_nx       = 32'(w_claim_id);
                            w_pending_clr   = w_claim_mask;
                            w_in_service_nx = w_claim_id;
                        end
                    end
                    default: begin
                        if (r_op_write) begin
                            if ((r_op_wdata[4:0] == r_in_service) && (r_in_service != 5'd0)) begin
                                w_in_service_nx = 5'd0;
                            end else begin
                                w_fault_nx = 1'b1;
                            end
                        end else begin
                            w_read_nx = 32'(r_in_service);
                        end
                    end
                endcase
            end
            DONE: begin
                w_busy_nx = available;
                if (!available) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_sync3      <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_in_service <= 5'd0;
            r_op_write   <= 1'b0;
            r_op_addr    <= 2'd0;
            r_op_wdata   <= '0;
            read_value   <= 32'd0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            ext_int      <= 1'b0;
        end else begin
            r_sync1      <= irq_in;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            // A fresh edge wins over a claim clearing the same bit.
            r_pending    <= (r_pending & ~w_pending_clr) | (r_sync2 & ~r_sync3);
            r_enable     <= w_enable_nx;
            r_in_service <= w_in_service_nx;
            read_value   <= w_read_nx;
            busy         <= w_busy_nx;
            fault        <= w_fault_nx;
            ext_int      <= (|w_claimable) & (r_in_service == 5'd0);
            if ((r_state == IDLE) && available) begin
                r_op_write <= write;
                r_op_addr  <= addr;
                r_op_wdata <= write_value[WD-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// tb_irq_ctrl : randomized self-checking bench with behavioural reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         available;
    logic         write;
    logic [1:0]   addr;
    logic [31:0]  write_value;
    logic [31:0]  read_value;
    logic         busy;
    logic         fault;
    logic         ext_int;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_SOURCES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .available  (available),
        .write      (write),
        .addr       (addr),
        .write_value(write_value),
        .read_value (read_value),
        .busy       (busy),
        .fault      (fault),
        .ext_int    (ext_int)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [N-1:0] m_pend, m_en;
    logic [N-1:0] hist0, hist1, hist2;   // irq_in seen at the last three edges
    logic [4:0]   m_is;
    logic         m_ext;
    logic [31:0]  m_rd;
    logic         m_fault;
    logic         op_go = 1'b0;
    logic         op_w;
    logic [1:0]   op_a;
    logic [31:0]  op_d;
    logic         rand_irq = 1'b0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    // One clock: advance the model across the posedge, compare ext_int at the negedge.
    task automatic tick();
        logic [N-1:0] rise, clr;
        logic         ext_nx;
        int           id;
        @(posedge clk);
        rise   = hist1 & ~hist2;
        ext_nx = (|(m_pend & m_en)) && (m_is == 5'd0);
        if (reset) begin
            m_pend = '0; m_en = '0; m_is = '0; m_ext = 1'b0;
            m_rd = '0; m_fault = 1'b0; op_go = 1'b0;
            hist0 = '0; hist1 = '0; hist2 = '0;
        end else begin
            clr     = '0;
            m_fault = 1'b0;
            if (op_go) begin
                op_go = 1'b0;
                m_rd  = '0;
                case (op_a)
                    2'd0: if (op_w) m_fault = 1'b1; else m_rd = 32'(m_pend);
                    2'd1: begin
                        m_rd = 32'(m_en);
                        if (op_w) m_en = op_d[N-1:0];
                    end
                    2'd2: begin
                        if (op_w || m_is != 5'd0) begin
                            m_fault = 1'b1;
                        end else begin
                            id = lowest(m_pend & m_en);
                            if (id > 0) begin
                                m_rd        = 32'(id);
                                clr[id - 1] = 1'b1;
                                m_is        = 5'(id);
                            end
                        end
                    end
                    default: begin
                        if (op_w) begin
                            if (op_d[4:0] == m_is && m_is != 5'd0) m_is = 5'd0;
                            else m_fault = 1'b1;
                        end else begin
                            m_rd = 32'(m_is);
                        end
                    end
                endcase
            end
            m_pend = (m_pend & ~clr) | rise;
            m_ext  = ext_nx;
            hist2  = hist1;
            hist1  = hist0;
            hist0  = irq_in;
        end
        @(negedge clk);
        checks++;
        if (ext_int !== m_ext) begin
            errors++;
            $display("FAIL ext_int @%0t: got %b want %b", $time, ext_int, m_ext);
        end
        if (rand_irq && ($urandom_range(0, 3) == 0)) irq_in = N'($urandom);
    endtask

    task automatic do_op(input logic w, input logic [1:0] a, input logic [31:0] d);
        available = 1'b1; write = w; addr = a; write_value = d;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL op_accept addr=%0d: busy got %b want 1", a, busy);
        end
        op_go = 1'b1; op_w = w; op_a = a; op_d = d;
        tick();
        checks++;
        if (busy !== 1'b0 || fault !== m_fault || read_value !== m_rd) begin
            errors++;
            $display("FAIL op_result addr=%0d w=%b: busy=%b fault=%b rd=%h want busy=0 fault=%b rd=%h",
                     a, w, busy, fault, read_value, m_fault, m_rd);
        end
        available = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || read_value !== m_rd) begin
            errors++;
            $display("FAIL op_done addr=%0d: busy=%b fault=%b rd=%h want busy=0 fault=0 rd=%h",
                     a, busy, fault, read_value, m_rd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_in = '0; available = 1'b0; write = 1'b0; addr = 2'd0; write_value = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || read_value !== 32'd0 || ext_int !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b fault=%b rd=%h ext=%b want all 0",
                     busy, fault, read_value, ext_int);
        end
    endtask

    task automatic test_single_source();
        do_op(1'b1, 2'd1, 32'h0000_0005);
        irq_in[2] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (ext_int !== 1'b0) begin
            errors++;
            $display("FAIL ext_int_early: got %b want 0", ext_int);
        end
        tick();
        checks++;
        if (ext_int !== 1'b1) begin
            errors++;
            $display("FAIL ext_int_rise: got %b want 1", ext_int);
        end
        irq_in[2] = 1'b0;
        do_op(1'b0, 2'd0, 32'd0);          // pending = 0x04
        do_op(1'b0, 2'd2, 32'd0);          // claim -> 3
        do_op(1'b0, 2'd0, 32'd0);          // pending = 0
        do_op(1'b1, 2'd3, 32'd3);          // complete
        tick(); tick();
    endtask

    task automatic test_priority();
        do_op(1'b1, 2'd1, 32'h0000_00FF);
        irq_in[1] = 1'b1; irq_in[6] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        do_op(1'b0, 2'd2, 32'd0);          // -> 2
        do_op(1'b0, 2'd2, 32'd0);          // in service -> fault
        do_op(1'b1, 2'd3, 32'd2);
        tick(); tick();
        do_op(1'b0, 2'd2, 32'd0);          // -> 7
        do_op(1'b1, 2'd3, 32'd7);
        tick();
    endtask

    task automatic test_faults();
        irq_in = '0;
        for (int i = 0; i < 3; i++) tick();
        irq_in[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        do_op(1'b0, 2'd2, 32'd0);          // -> 2
        do_op(1'b1, 2'd3, 32'd5);          // wrong id -> fault
        do_op(1'b0, 2'd3, 32'd0);          // still 2
        do_op(1'b1, 2'd0, 32'hFFFF_FFFF);  // pending write -> fault
        do_op(1'b0, 2'd0, 32'd0);
        do_op(1'b1, 2'd2, 32'd0);          // claim write -> fault
    endtask

    task automatic test_reset_mid_op();
        available = 1'b1; write = 1'b0; addr = 2'd1; write_value = '0;
        tick();
        op_go = 1'b1; op_w = 1'b0; op_a = 2'd1; op_d = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL done_hold_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || read_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b rd=%h want 0/0", busy, read_value);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_accept: busy got %b want 1", busy);
        end
        op_go = 1'b1; op_w = 1'b0; op_a = 2'd1; op_d = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || read_value !== m_rd) begin
            errors++;
            $display("FAIL restart_result: busy=%b rd=%h want 0/%h", busy, read_value, m_rd);
        end
        available = 1'b0;
        tick();
        do_op(1'b0, 2'd3, 32'd0);          // in_service cleared
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic        w;
        logic [31:0] d;
        rand_irq = 1'b1;
        do_op(1'b1, 2'd1, 32'h0000_00FF);
        for (int n = 0; n < 250; n++) begin
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            d = $urandom;
            if (a == 2'd3) begin
                w = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) != 0) d = 32'(m_is);
            end
            if (a == 2'd2 && $urandom_range(0, 1) == 1) w = 1'b0;
            do_op(w, a, d);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        end
        rand_irq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_priority();
        test_faults();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
